// File: rtl/ksa.sv
// RC4 key-scheduling engine: walks i over 0..255 against an external 256x8
// synchronous-read S memory, accumulating j and swapping S[i] / S[j].
module ksa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [23:0] key_q, key_d;
  logic [1:0]  kidx_q, kidx_d;   // tracks i mod 3 without a divider
  logic [7:0]  key_byte;

  always_comb begin
    unique case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // State register. S itself lives outside this block, so an aborted run
  // leaves whatever swaps already landed in memory.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= 24'd0;
      kidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every comb output is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          key_d   = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
          state_d = RD_I;
        end
      end
      RD_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte;
        state_d = RD_J;
      end
      RD_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = s_rddata;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; when i==j both writes hit the
  // same address with the same value, so the location is left unchanged.
  always_comb begin
    rdy      = 1'b0;
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    unique case (state_q)
      IDLE: rdy = 1'b1;
      RD_I: s_addr = i_q;
      RD_J: s_addr = j_q;
      WR_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: behavioural S memory, software KSA model feeding a
// write-pair scoreboard, and run-length / write-count checks.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  always #5 clk = ~clk;

  ksa dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  log_w[4];
  int   log_n;
  int   wren_cnt;
  int   rdy_low_cnt;

  logic [7:0] mem[256];
  logic [7:0] ms[256];
  logic       fill_id;
  logic [7:0] fill_s0;

  // S memory: 1-cycle synchronous read, write on the edge while s_wren.
  always @(posedge clk) begin
    if (fill_id) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      mem[0] <= fill_s0;
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
    end
    s_rddata <= mem[s_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!rdy) rdy_low_cnt++;
      if (s_wren) begin
        wr_t w;
        wren_cnt++;
        w.addr = s_addr;
        w.data = s_wrdata;
        if (log_n < 4) begin
          log_w[log_n] = w;
          log_n++;
        end
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", w.addr, e.addr);
          check("wr_data", w.data, e.data);
        end
      end
    end
  end

  task automatic model_run(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    wr_t        w;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = (i % 3 == 0) ? k[23:16] : (i % 3 == 1) ? k[15:8] : k[7:0];
      j = j + ms[i] + kb;
      w.addr = 8'(i); w.data = ms[j]; exp_q.push_back(w);
      w.addr = j;     w.data = ms[i]; exp_q.push_back(w);
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
    end
  endtask

  task automatic fill(input logic [7:0] s0);
    @(negedge clk);
    fill_id = 1'b1;
    fill_s0 = s0;
    @(negedge clk);
    fill_id = 1'b0;
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    ms[0] = s0;
  endtask

  task automatic start_run(input logic [23:0] k, input bit keep_en);
    @(negedge clk);
    key         = k;
    en          = 1'b1;
    log_n       = 0;
    wren_cnt    = 0;
    rdy_low_cnt = 0;
    @(posedge clk);
    #1;
    check("accept_rdy_low", rdy, 0);
    if (!keep_en) en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, rdy, 1);
  endtask

  task automatic check_result(input string tag);
    int bad;
    bad = 0;
    check({tag, "_rdy_low"}, rdy_low_cnt, 1536);
    check({tag, "_wren"}, wren_cnt, 512);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ms[k]) begin
        if (bad == 0) check({tag, "_final_s_first_bad"}, mem[k], ms[k]);
        bad++;
      end
    end
    check({tag, "_final_s_bad_bytes"}, bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; key = 24'd0; fill_id = 1'b0; fill_s0 = 8'd0;
    log_n = 0; wren_cnt = 0; rdy_low_cnt = 0;

    // Reset is visible before the first edge and held across it.
    #3;
    check("rst_rdy", rdy, 1);
    check("rst_wren", s_wren, 0);
    check("rst_addr", s_addr, 0);
    check("rst_wrdata", s_wrdata, 0);
    @(posedge clk); #1;
    check("rst_hold_rdy", rdy, 1);
    @(negedge clk); rst_n = 1'b1;

    // Identity S, reference key.
    fill(8'd0);
    model_run(24'h00033C);
    start_run(24'h00033C, 1'b0);
    wait_done("ref");
    check("ref_w0_addr", log_w[0].addr, 8'd0);
    check("ref_w0_data", log_w[0].data, 8'd0);
    check("ref_w1_addr", log_w[1].addr, 8'd0);
    check("ref_w1_data", log_w[1].data, 8'd0);
    check("ref_w2_addr", log_w[2].addr, 8'd1);
    check("ref_w2_data", log_w[2].data, 8'd4);
    check("ref_w3_addr", log_w[3].addr, 8'd4);
    check("ref_w3_data", log_w[3].data, 8'd1);
    check_result("ref");

    // j wrap: S[0]=FF, key all ones -> j = FF+FF = FE after CAP_I.
    fill(8'hFF);
    model_run(24'hFFFFFF);
    start_run(24'hFFFFFF, 1'b0);
    @(negedge clk);
    check("wrap_rd_i_addr", s_addr, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("wrap_rd_j_addr", s_addr, 8'hFE);
    check("wrap_rd_j_wren", s_wren, 0);
    wait_done("wrap");
    check_result("wrap");

    // en pulses and key changes mid-run are ignored.
    fill(8'd0);
    model_run(24'h5A17C3);
    start_run(24'h5A17C3, 1'b0);
    repeat (50) @(negedge clk);
    en = 1'b1; key = 24'hABCDEF;
    repeat (5) @(negedge clk);
    en = 1'b0; key = 24'h123456;
    wait_done("midkey");
    check_result("midkey");

    // Reset 100 cycles into a run aborts immediately.
    fill(8'd0);
    model_run(24'h010203);
    start_run(24'h010203, 1'b0);
    repeat (100) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("midrst_rdy", rdy, 1);
    check("midrst_wren", s_wren, 0);
    check("midrst_addr", s_addr, 0);
    @(posedge clk); #1;
    check("midrst_hold_rdy", rdy, 1);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    fill(8'd0);
    model_run(24'h0A0B0C);
    start_run(24'h0A0B0C, 1'b0);
    wait_done("postrst");
    check_result("postrst");

    // Back-to-back: en held high restarts in the cycle rdy rises.
    fill(8'd0);
    model_run(24'hC0FFEE);
    model_run(24'hC0FFEE);
    start_run(24'hC0FFEE, 1'b1);
    wait_done("b2b1");
    check("b2b1_rdy_low", rdy_low_cnt, 1536);
    check("b2b1_wren", wren_cnt, 512);
    rdy_low_cnt = 0;
    wren_cnt    = 0;
    @(posedge clk); #1;
    check("b2b_restart_rdy", rdy, 0);
    en = 1'b0;
    wait_done("b2b2");
    check_result("b2b2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
